// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared types and constants for the regfile_mp register file
package regfile_mp_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [63:0] ZERO_WORD = '0;
  localparam logic WRITE_EN = 1'b1;
  localparam logic READ_EN  = 1'b1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with pending-flag select
// Same-cycle write forwarding is present only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              active,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]  pend,
`ifdef REGFILE_BYPASS_EN
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              rpend
);

  always_comb begin
    rdata = DATA_W'(ZERO_WORD);
    rpend = 1'b0;
    if (active && re == READ_EN && raddr != '0) begin
      rdata = regs[raddr];
      rpend = pend[raddr];
`ifdef REGFILE_BYPASS_EN
      // the write landing this cycle is the newest value and retires the pending producer
      if (we == WRITE_EN && waddr == raddr) begin
        rdata = wdata;
        rpend = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with clear sweep and pending scoreboard
// Optional same-cycle write forwarding on read ports: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [N_RD-1:0]          re,
  input  logic [N_RD*ADDR_W-1:0]   raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  output logic [N_RD-1:0]          rpend
);

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    pend;
  logic [DEPTH-1:0]    pend_next;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                rd_active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_INIT;
      clr_idx   <= ADDR_W'(1);
      pend      <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_READY;
            init_busy <= 1'b0;
          end
        end
        default: pend <= pend_next;
      endcase
    end
  end

  // the sweep and the WB port share the single array write port
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = waddr;
    rf_wdata = wdata;
    if (rst) begin
      if (state == ST_INIT) begin
        rf_we    = 1'b1;
        rf_waddr = clr_idx;
        rf_wdata = DATA_W'(ZERO_WORD);
      end else begin
        rf_we = (we == WRITE_EN) && (waddr != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  // a new allocation outranks a retiring write to the same register
  always_comb begin
    pend_next = pend;
    if (we == WRITE_EN) pend_next[waddr] = 1'b0;
    if (alloc_en && alloc_addr != '0) pend_next[alloc_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  assign rd_active = rst && (state == ST_READY);

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    regfile_rd_port #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_rd_port (
      .active(rd_active),
      .re    (re[gi]),
      .raddr (raddr[gi*ADDR_W +: ADDR_W]),
      .regs  (regs),
      .pend  (pend),
`ifdef REGFILE_BYPASS_EN
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
`endif
      .rdata (rdata[gi*DATA_W +: DATA_W]),
      .rpend (rpend[gi])
    );
  end

endmodule
